// File: rtl/ula_seq.sv
// ula_seq: sequential WIDTH-bit ALU for the MIPS32 datapath.
//
// Logic ops (AND/OR/XOR/NOR), ADD/SUB with carry and signed overflow,
// signed SLT, all with a registered result (latency 1), plus an iterative
// shift-add unsigned multiply (MULTU) producing a 2*WIDTH-bit HI/LO
// product (latency WIDTH+1).
//
// Ports:
//   clk, rst_n            clock (rising edge), async active-low reset
//   in_valid / in_ready   request handshake; in_ready only in IDLE
//   op, a, b              operation code and operands, captured on accept
//   out_valid / out_ready result handshake; outputs held until taken
//   result                result word (LO word for MULTU)
//   result_hi             MULTU high word, 0 for every other op
//   zero                  result == 0 (low word only)
//   carry, overflow       add/sub carry out and signed overflow
module ula_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             zero,
  output logic             carry,
  output logic             overflow
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DONE
  } state_t;

  typedef enum logic [2:0] {
    OP_AND   = 3'b000,
    OP_OR    = 3'b001,
    OP_ADD   = 3'b010,
    OP_XOR   = 3'b011,
    OP_NOR   = 3'b100,
    OP_MULTU = 3'b101,
    OP_SUB   = 3'b110,
    OP_SLT   = 3'b111
  } op_t;

  // State and output registers
  state_t           state_q, state_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic             zero_q, zero_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;

  // Multiplier working registers
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  // ---------------------------------------------------------------------
  // Single-cycle datapath (operates directly on the request inputs, so the
  // result is registered on the acceptance edge)
  // ---------------------------------------------------------------------
  logic             as_sub;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   as_sum;
  logic             as_ovf;
  logic             slt_lt;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c;
  logic             alu_v;

  always_comb begin
    // SLT shares the subtract path with SUB; only ADD adds.
    as_sub = (op != OP_ADD);
    b_eff  = as_sub ? ~b : b;
    as_sum = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, as_sub};
    // Overflow: operands (after inversion) agree in sign, sum differs.
    as_ovf = (a[WIDTH-1] == b_eff[WIDTH-1]) && (as_sum[WIDTH-1] != a[WIDTH-1]);
    slt_lt = as_sum[WIDTH-1] ^ as_ovf;
  end

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (op)
      OP_AND: alu_res = a & b;
      OP_OR:  alu_res = a | b;
      OP_XOR: alu_res = a ^ b;
      OP_NOR: alu_res = ~(a | b);
      OP_ADD, OP_SUB: begin
        alu_res = as_sum[WIDTH-1:0];
        alu_c   = as_sum[WIDTH];
        alu_v   = as_ovf;
      end
      OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, slt_lt};
      default: alu_res = '0;
    endcase
  end

  // ---------------------------------------------------------------------
  // Multiply step: add multiplicand into the upper half when multiplier[0]
  // is set, then shift {carry, acc, multiplier} right by one. After WIDTH
  // steps {acc, multiplier} holds the full product.
  // ---------------------------------------------------------------------
  logic [WIDTH:0]   mul_pp;
  logic [WIDTH-1:0] acc_nx;
  logic [WIDTH-1:0] mpl_nx;

  always_comb begin
    mul_pp = {1'b0, acc_q} + {1'b0, (mplier_q[0] ? mcand_q : {WIDTH{1'b0}})};
    acc_nx = mul_pp[WIDTH:1];
    mpl_nx = {mul_pp[0], mplier_q[WIDTH-1:1]};
  end

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    res_d    = res_q;
    hi_d     = hi_q;
    zero_d   = zero_q;
    carry_d  = carry_q;
    ovf_d    = ovf_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          if (op == OP_MULTU) begin
            state_d  = S_MUL;
            mcand_d  = a;
            mplier_d = b;
            acc_d    = '0;
            cnt_d    = '0;
          end else begin
            state_d = S_DONE;
            res_d   = alu_res;
            hi_d    = '0;
            zero_d  = (alu_res == '0);
            carry_d = alu_c;
            ovf_d   = alu_v;
          end
        end
      end

      S_MUL: begin
        mplier_d = mpl_nx;
        acc_d    = acc_nx;
        cnt_d    = cnt_q + CW'(1);
        // Final iteration writes the product straight into the output
        // registers so out_valid rises WIDTH+1 edges after acceptance.
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = S_DONE;
          res_d   = mpl_nx;
          hi_d    = acc_nx;
          zero_d  = (mpl_nx == '0);
          carry_d = 1'b0;
          ovf_d   = 1'b0;
        end
      end

      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      res_q    <= '0;
      hi_q     <= '0;
      zero_q   <= 1'b0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      res_q    <= res_d;
      hi_q     <= hi_d;
      zero_q   <= zero_d;
      carry_q  <= carry_d;
      ovf_q    <= ovf_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
    end
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign result    = res_q;
  assign result_hi = hi_q;
  assign zero      = zero_q;
  assign carry     = carry_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_ula_seq.sv
// Testbench for ula_seq: directed vectors with hand-computed results.
// Stimulus pushes expected responses into a queue; a monitor pops and
// compares each time a result is handed over (out_valid && out_ready).
module tb_ula_seq;

  localparam int W = 32;

  localparam logic [2:0] OP_AND   = 3'b000;
  localparam logic [2:0] OP_OR    = 3'b001;
  localparam logic [2:0] OP_ADD   = 3'b010;
  localparam logic [2:0] OP_XOR   = 3'b011;
  localparam logic [2:0] OP_NOR   = 3'b100;
  localparam logic [2:0] OP_MULTU = 3'b101;
  localparam logic [2:0] OP_SUB   = 3'b110;
  localparam logic [2:0] OP_SLT   = 3'b111;

  typedef struct packed {
    logic [W-1:0] res;
    logic [W-1:0] hi;
    logic         z;
    logic         c;
    logic         v;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic [W-1:0] result_hi;
  logic         zero;
  logic         carry;
  logic         overflow;

  int checks = 0;
  int errors = 0;
  exp_t sb[$];

  ula_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .result_hi (result_hi),
    .zero      (zero),
    .carry     (carry),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t mk(input logic [W-1:0] r, input logic [W-1:0] h,
                              input logic z, input logic c, input logic v);
    exp_t e;
    e.res = r;
    e.hi  = h;
    e.z   = z;
    e.c   = c;
    e.v   = v;
    return e;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, req);
    end
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got result %h, expected no output", result);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("result",    64'(result),    64'(e.res));
        chk("result_hi", 64'(result_hi), 64'(e.hi));
        chk("zero",      64'(zero),      64'(e.z));
        chk("carry",     64'(carry),     64'(e.c));
        chk("overflow",  64'(overflow),  64'(e.v));
      end
    end
  end

  // Wait (at negedges) for in_ready, bounded.
  task automatic wait_ready(input string nm);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk({nm, "_ready_timeout"}, 64'(in_ready), 64'd1);
  endtask

  // Issue one request, push its expectation, and measure latency.
  task automatic issue(input string nm, input logic [2:0] o, input logic [W-1:0] av,
                       input logic [W-1:0] bv, input exp_t e, input int lat_req);
    int lat;
    wait_ready(nm);
    in_valid = 1'b1;
    op = o;
    a  = av;
    b  = bv;
    sb.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = $urandom;
    b = $urandom;
    lat = 1;
    @(negedge clk);
    while (!out_valid && lat < 200) begin
      if (in_ready) chk({nm, "_in_ready_busy"}, 64'(in_ready), 64'd0);
      @(negedge clk);
      lat++;
    end
    chk({nm, "_latency"}, 64'(lat), 64'(lat_req));
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    op        = 3'b000;
    a         = '0;
    b         = '0;
    out_ready = 1'b1;

    repeat (3) @(negedge clk);
    // Reset state
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_result",    64'(result),    64'd0);
    chk("rst_in_ready",  64'(in_ready),  64'd1);
    rst_n = 1'b1;

    issue("add_ovf", OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001, mk(32'h8000_0000, '0, 0, 0, 1), 1);
    issue("add_carry", OP_ADD, 32'hFFFF_FFFF, 32'h0000_0001, mk(32'h0000_0000, '0, 1, 1, 0), 1);
    issue("sub_eq", OP_SUB, 32'd5, 32'd5, mk(32'h0, '0, 1, 1, 0), 1);
    issue("sub_borrow", OP_SUB, 32'd3, 32'd5, mk(32'hFFFF_FFFE, '0, 0, 0, 0), 1);
    issue("slt_neg", OP_SLT, 32'hFFFF_FFFF, 32'h0000_0001, mk(32'h1, '0, 0, 0, 0), 1);
    issue("slt_pos", OP_SLT, 32'h0000_0001, 32'hFFFF_FFFF, mk(32'h0, '0, 1, 0, 0), 1);
    issue("slt_ovf", OP_SLT, 32'h8000_0000, 32'h7FFF_FFFF, mk(32'h1, '0, 0, 0, 0), 1);
    issue("and", OP_AND, 32'hF0F0_F0F0, 32'hFF00_FF00, mk(32'hF000_F000, '0, 0, 0, 0), 1);
    issue("or",  OP_OR,  32'hF0F0_F0F0, 32'hFF00_FF00, mk(32'hFFF0_FFF0, '0, 0, 0, 0), 1);
    issue("xor", OP_XOR, 32'hF0F0_F0F0, 32'hFF00_FF00, mk(32'h0FF0_0FF0, '0, 0, 0, 0), 1);
    issue("nor", OP_NOR, 32'hF0F0_F0F0, 32'hFF00_FF00, mk(32'h000F_000F, '0, 0, 0, 0), 1);
    issue("mul_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
          mk(32'h0000_0001, 32'hFFFF_FFFE, 0, 0, 0), W + 1);
    issue("mul_zero", OP_MULTU, 32'h1234_5678, 32'h0, mk(32'h0, 32'h0, 1, 0, 0), W + 1);
    issue("mul_hi_only", OP_MULTU, 32'h0001_0000, 32'h0001_0000,
          mk(32'h0, 32'h0000_0001, 1, 0, 0), W + 1);
    issue("mul_small", OP_MULTU, 32'd3, 32'd5, mk(32'd15, 32'h0, 0, 0, 0), W + 1);

    // Backpressure: result held while out_ready is low and a new request waits
    wait_ready("bp_pre");
    out_ready = 1'b0;
    issue("bp_add", OP_ADD, 32'h8000_0000, 32'hFFFF_FFFF, mk(32'h7FFF_FFFF, '0, 0, 1, 1), 1);
    in_valid = 1'b1;
    op = OP_XOR;
    a  = 32'hF0F0_F0F0;
    b  = 32'hFF00_FF00;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_hold_valid",    64'(out_valid), 64'd1);
      chk("bp_hold_result",   64'(result),    64'h7FFF_FFFF);
      chk("bp_hold_carry",    64'(carry),     64'd1);
      chk("bp_hold_overflow", 64'(overflow),  64'd1);
      chk("bp_hold_in_ready", 64'(in_ready),  64'd0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_valid_before_hs", 64'(out_valid), 64'd1);
    chk("bp_in_ready_before_hs", 64'(in_ready), 64'd0);
    sb.push_back(mk(32'h0FF0_0FF0, '0, 0, 0, 0));
    @(negedge clk);
    // Handshake edge has passed: idle for one cycle, request not yet taken
    chk("bp_valid_after_hs", 64'(out_valid), 64'd0);
    chk("bp_in_ready_after_hs", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("bp_new_latency", 64'(out_valid), 64'd1);

    // Asynchronous reset during the 10th MUL cycle
    wait_ready("rst_mul");
    in_valid = 1'b1;
    op = OP_MULTU;
    a  = 32'hFFFF_FFFF;
    b  = 32'hFFFF_FFFF;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #2;
    chk("mid_mul_in_ready", 64'(in_ready), 64'd0);
    chk("mid_mul_result_held", 64'(result), 64'h0FF0_0FF0);
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_result",    64'(result),    64'd0);
    chk("arst_result_hi", 64'(result_hi), 64'd0);
    chk("arst_zero",      64'(zero),      64'd0);
    chk("arst_carry",     64'(carry),     64'd0);
    chk("arst_overflow",  64'(overflow),  64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    issue("add_after_rst", OP_ADD, 32'd2, 32'd3, mk(32'd5, '0, 0, 0, 0), 1);

    repeat (5) @(negedge clk);
    chk("idle_no_output", 64'(out_valid), 64'd0);
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ula_seq.md
Name: ula_seq

Overview:
Parametrised WIDTH-bit successor to the 1-bit ALU slice for the MIPS32 datapath. It performs the logic, add/sub and set-less-than operations with a registered result, and adds an iterative unsigned multiply (MULTU) that produces HI/LO. Operands enter through a valid/ready handshake, and results leave through a second valid/ready handshake. The block sits between the register-file read stage and writeback/HI-LO registers.

Parameters:
WIDTH, 32, operand/result width in bits; legal values are >= 2.

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand/op request valid
in_ready  output  1  block can accept a request
op  input  3  operation code (see Behaviour)
a  input  WIDTH  operand A
b  input  WIDTH  operand B
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
result  output  WIDTH  result; for MULTU, the LO word
result_hi  output  WIDTH  MULTU high word; 0 for every other op
zero  output  1  result == 0 (low word only)
carry  output  1  carry out of add/sub
overflow  output  1  signed overflow of add/sub

Behaviour:
- Op encoding:
  - 000 AND, 001 OR, 011 XOR, 100 NOR.
  - 010 ADD (a+b), 110 SUB (a+~b+1).
  - 111 SLT: signed a<b → result = {0…,1} or 0.
  - 101 MULTU: unsigned a*b, 2*WIDTH-bit product.
  - All eight codes are defined.
- States: IDLE, MUL, DONE.
- in_ready = 1 only in IDLE. While rst_n is low, state is IDLE and in_valid is ignored.
- Acceptance: in_valid && in_ready at a rising edge. op, a and b are captured at acceptance; later input changes have no effect.
- Single-cycle ops (all except 101):
  - The result and flags are registered on the acceptance edge, and the state moves to DONE.
  - out_valid is asserted on the cycle after acceptance (latency 1).
- MULTU:
  - IDLE→MUL on acceptance. Load multiplicand = a, multiplier = b, acc = 0, cnt = 0.
  - Each MUL cycle, shift-add one bit: if multiplier[0], add multiplicand into the upper half of {carry, acc_hi}; then shift {carry, acc_hi, multiplier} right by 1; cnt++.
  - After WIDTH iterations, {result_hi, result} = product and the state moves to DONE.
  - out_valid is asserted exactly WIDTH+1 cycles after the acceptance edge.
- Flags:
  - ADD/SUB: carry = MSB carry out (for SUB, carry = 1 means no borrow); overflow = signed overflow.
  - SLT: lt = sign(a-b) XOR overflow(a-b). carry and overflow are 0.
  - All other ops: carry = overflow = 0.
  - zero is valid for every op.
- DONE: out_valid = 1. result, result_hi and all flags are held stable until out_valid && out_ready. On that edge the state returns to IDLE and out_valid drops. There is no bypass, so a new request is accepted no earlier than the following cycle.
- Reset values (including asynchronous reset mid-operation): state IDLE; out_valid, result, result_hi, zero, carry and overflow = 0; internal multiplier registers and cnt = 0. A multiply in flight is aborted with no output.
- Width rules: all arithmetic is modulo 2^WIDTH except the MULTU product (2^(2*WIDTH)). cnt is sized $clog2(WIDTH)+1 bits.

Test Plan:
- ADD, a=0x7FFFFFFF, b=0x00000001 → out_valid 1 cycle after accept; result=0x80000000, overflow=1, carry=0, zero=0, result_hi=0.
- SUB 5-5 → result=0, zero=1, carry=1, overflow=0. SLT with a=0xFFFFFFFF, b=0x00000001 → result=1; SLT 1 vs -1 → result=0.
- Logic ops with a=0xF0F0F0F0, b=0xFF00FF00 → AND 0xF000F000, OR 0xFFF0FFF0, XOR 0x0FF00FF0, NOR 0x000F000F.
- MULTU 0xFFFFFFFF*0xFFFFFFFF → result_hi=0xFFFFFFFE, result=0x00000001, out_valid exactly 33 cycles after accept, in_ready=0 throughout. 0x12345678*0 → zero=1, result_hi=0.
- Backpressure: hold out_ready=0 for 5 cycles with in_valid=1 and new operands → result and flags stay constant, in_ready=0. The new request is accepted on the cycle after the out_valid/out_ready handshake.
- Deassert rst_n on the 10th MUL cycle → all outputs 0 immediately, state IDLE. After release, ADD 2+3 → result=5 with latency 1.
